// File: rtl/terminal_report_tx.sv
// Builds VT102 DSR/DA/CPR reply sequences and streams them to the UART over valid/ready.
// termMode packs {origin_mode, scroll_top[7:0]}; param carries Pn1.
module terminal_report_tx #(
  parameter logic [7:0] DA_CLASS = 8'h36,
  parameter logic [7:0] CMD_DSR  = 8'h6E,
  parameter logic [7:0] CMD_DA   = 8'h63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commandReady,
  input  logic [7:0]  commandType,
  input  logic [15:0] param,
  input  logic [8:0]  termMode,
  input  logic [7:0]  cursor_row,
  input  logic [7:0]  cursor_col,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        dropped
);

  localparam int unsigned BUF_LEN = 10;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_next;
  logic [7:0]        buf_q [BUF_LEN];
  logic [IDX_W-1:0]  len_q, idx_q;
  logic              req_valid, hs, last;
  logic              accept, drop_c, advance, finish;
  logic              origin_mode;
  logic [7:0]        scroll_top;
  logic [8:0]        r_val, c_val;
  logic [25:0]       r_dec, c_dec;
  logic [7:0]        build [BUF_LEN];
  logic [IDX_W-1:0]  build_len, p;

  assign origin_mode = termMode[8];
  assign scroll_top  = termMode[7:0];
  assign hs          = tx_valid && tx_ready;
  assign last        = (idx_q == len_q - IDX_W'(1));

  // {digit count, hundreds, tens, ones} in ASCII for a value 1..256
  function automatic logic [25:0] dec3(input logic [8:0] v);
    logic [1:0] n;
    logic [7:0] h, t, o;
    h = 8'h30 + 8'(v / 9'd100);
    t = 8'h30 + 8'((v / 9'd10) % 9'd10);
    o = 8'h30 + 8'(v % 9'd10);
    n = (v >= 9'd100) ? 2'd3 : ((v >= 9'd10) ? 2'd2 : 2'd1);
    return {n, h, t, o};
  endfunction

  always_comb begin
    req_valid = 1'b0;
    if (commandReady) begin
      if (commandType == CMD_DSR && (param == 16'd5 || param == 16'd6)) req_valid = 1'b1;
      if (commandType == CMD_DA && param == 16'd0) req_valid = 1'b1;
    end
  end

  // cursor position report values, origin-relative rows clamp to 1 above the margin
  always_comb begin
    c_val = 9'(cursor_col) + 9'd1;
    if (!origin_mode)                 r_val = 9'(cursor_row) + 9'd1;
    else if (cursor_row < scroll_top) r_val = 9'd1;
    else                              r_val = 9'(cursor_row) - 9'(scroll_top) + 9'd1;
  end

  assign r_dec = dec3(r_val);
  assign c_dec = dec3(c_val);

  always_comb begin
    for (int i = 0; i < int'(BUF_LEN); i++) build[i] = 8'h00;
    build[0]  = 8'h1B;
    build[1]  = 8'h5B;
    p         = IDX_W'(2);
    build_len = IDX_W'(4);
    if (commandType == CMD_DA) begin
      build[2]  = 8'h3F;
      build[3]  = DA_CLASS;
      build[4]  = 8'h63;
      build_len = IDX_W'(5);
    end else if (param == 16'd5) begin
      build[2]  = 8'h30;
      build[3]  = 8'h6E;
      build_len = IDX_W'(4);
    end else begin
      if (r_dec[25:24] == 2'd3) begin build[p] = r_dec[23:16]; p = p + IDX_W'(1); end
      if (r_dec[25:24] >= 2'd2) begin build[p] = r_dec[15:8];  p = p + IDX_W'(1); end
      build[p] = r_dec[7:0];  p = p + IDX_W'(1);
      build[p] = 8'h3B;       p = p + IDX_W'(1);
      if (c_dec[25:24] == 2'd3) begin build[p] = c_dec[23:16]; p = p + IDX_W'(1); end
      if (c_dec[25:24] >= 2'd2) begin build[p] = c_dec[15:8];  p = p + IDX_W'(1); end
      build[p] = c_dec[7:0];  p = p + IDX_W'(1);
      build[p] = 8'h52;
      build_len = p + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid)    state_next = SEND;
      SEND:    if (hs && last)   state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    accept  = (state == IDLE) && req_valid;
    drop_c  = (state == SEND) && req_valid;
    advance = (state == SEND) && hs && !last;
    finish  = (state == SEND) && hs && last;
  end

  // reply buffer and registered transmit outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BUF_LEN); i++) buf_q[i] <= 8'h00;
      len_q    <= '0;
      idx_q    <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      dropped <= drop_c;
      busy    <= (state_next == SEND);
      if (accept) begin
        for (int i = 0; i < int'(BUF_LEN); i++) buf_q[i] <= build[i];
        len_q    <= build_len;
        idx_q    <= '0;
        tx_data  <= build[0];
        tx_valid <= 1'b1;
      end else if (advance) begin
        idx_q   <= idx_q + IDX_W'(1);
        tx_data <= buf_q[idx_q + IDX_W'(1)];
      end else if (finish) begin
        idx_q    <= '0;
        tx_data  <= 8'h00;
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_terminal_report_tx.sv
// Randomized bench for terminal_report_tx against a string-formatting reply model.
module tb_terminal_report_tx;

  localparam logic [7:0] DSR      = 8'h6E;
  localparam logic [7:0] DA       = 8'h63;
  localparam logic [7:0] DECSTBM  = 8'h72;
  localparam logic [7:0] DA_CLASS = 8'h36;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commandReady = 1'b0;
  logic [7:0]  commandType = 8'h00;
  logic [15:0] param = 16'h0000;
  logic [8:0]  termMode = 9'h000;
  logic [7:0]  cursor_row = 8'h00;
  logic [7:0]  cursor_col = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        dropped;

  int n_err = 0;
  int n_chk = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  bit         ok;

  terminal_report_tx #(.DA_CLASS(DA_CLASS), .CMD_DSR(DSR), .CMD_DA(DA)) dut (
    .clk(clk), .rst(rst), .commandReady(commandReady), .commandType(commandType),
    .param(param), .termMode(termMode), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reply as the host should see it: ESC followed by the printable tail
  function automatic void model(input logic [7:0] cmd, input logic [15:0] pn, input int row,
                                input int col, input int om, input int top, output bit valid);
    string s;
    int r;
    int c;
    exp_q.delete();
    valid = 1'b0;
    s = "";
    if (cmd == DSR && pn == 16'd5) begin
      s = "[0n"; valid = 1'b1;
    end else if (cmd == DSR && pn == 16'd6) begin
      c = col + 1;
      if (om != 0) r = (row < top) ? 1 : row - top + 1;
      else         r = row + 1;
      s = $sformatf("[%0d;%0dR", r, c); valid = 1'b1;
    end else if (cmd == DA && pn == 16'd0) begin
      s = $sformatf("[?%cc", DA_CLASS); valid = 1'b1;
    end
    if (valid) begin
      exp_q.push_back(8'h1B);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    end
  endfunction

  // one clock: log handshake, check stall stability, then sample #1 after the edge
  task automatic clk_step();
    if (stall_prev) begin
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_data", 32'(tx_data), 32'(stall_data));
    end
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    stall_prev = tx_valid && !tx_ready;
    stall_data = tx_data;
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [7:0] cmd, input logic [15:0] pn, input int row,
                           input int col, input int om, input int top, output bit valid);
    model(cmd, pn, row, col, om, top, valid);
    got_q.delete();
    commandType  = cmd;
    param        = pn;
    cursor_row   = 8'(row);
    cursor_col   = 8'(col);
    termMode     = {1'(om), 8'(top)};
    commandReady = 1'b1;
    clk_step();
    commandReady = 1'b0;
    cursor_row   = 8'($urandom);
    cursor_col   = 8'($urandom);
    termMode     = 9'($urandom);
    param        = 16'($urandom);
    if (valid) begin
      check("first_valid", 32'(tx_valid), 32'd1);
      check("first_byte", 32'(tx_data), 32'h1B);
      check("busy_on", 32'(busy), 32'd1);
    end else begin
      check("ign_valid", 32'(tx_valid), 32'd0);
      check("ign_busy", 32'(busy), 32'd0);
      check("ign_dropped", 32'(dropped), 32'd0);
    end
  endtask

  task automatic compare_got(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD,
            32'(exp_q[i]));
  endtask

  task automatic drain(input bit rnd, input string tag);
    int cyc = 0;
    int busy_cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 200) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (busy) busy_cyc++;
      clk_step();
      cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc < 200), 32'd1);
    check({tag, "_end_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    compare_got(tag);
    if (!rnd) check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_q.size()));
    tx_ready = 1'b1;
  endtask

  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      clk_step();
      check({tag, "_quiet_valid"}, 32'(tx_valid), 32'd0);
      check({tag, "_quiet_dropped"}, 32'(dropped), 32'd0);
    end
    check({tag, "_quiet_bytes"}, 32'(got_q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    rst = 1'b0;
    clk_step();
    tx_ready = 1'b1;

    start_req(DSR, 16'd5, 0, 0, 0, 0, ok);     drain(1'b0, "dsr5");
    start_req(DSR, 16'd6, 4, 79, 0, 0, ok);    drain(1'b0, "cpr_5_80");
    start_req(DSR, 16'd6, 255, 0, 0, 0, ok);   drain(1'b0, "cpr_256_1");
    start_req(DSR, 16'd6, 2, 0, 1, 3, ok);     drain(1'b0, "cpr_org_clamp");
    start_req(DSR, 16'd6, 10, 0, 1, 3, ok);    drain(1'b0, "cpr_org_8");
    start_req(DSR, 16'd6, 255, 255, 0, 0, ok); drain(1'b1, "cpr_max");
    tx_ready = 1'b0;
    start_req(DA, 16'd0, 0, 0, 0, 0, ok);      drain(1'b1, "da");

    for (int k = 0; k < 30; k++) begin
      int kind;
      logic [7:0] cmd;
      logic [15:0] pn;
      kind = $urandom_range(0, 4);
      cmd = DSR;
      pn = 16'd6;
      case (kind)
        0: pn = 16'd5;
        2: begin cmd = DA; pn = 16'd0; end
        3: pn = 16'($urandom_range(0, 12));
        4: begin cmd = ($urandom_range(0, 1) != 0) ? DA : DECSTBM; pn = 16'($urandom_range(1, 4)); end
        default: pn = 16'd6;
      endcase
      tx_ready = 1'($urandom_range(0, 1));
      start_req(cmd, pn, $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 1), $urandom_range(0, 255), ok);
      if (ok) drain(1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
      else    quiet(3, $sformatf("rnd%0d", k));
    end

    // overlapping requests are dropped mid-reply and on the final handshake
    tx_ready = 1'b1;
    start_req(DSR, 16'd6, 99, 199, 0, 0, ok);
    clk_step();
    clk_step();
    commandType = DSR; param = 16'd5; commandReady = 1'b1;
    clk_step();
    commandReady = 1'b0;
    check("drop_mid", 32'(dropped), 32'd1);
    clk_step();
    check("drop_pulse_end", 32'(dropped), 32'd0);
    for (int i = 0; i < 20 && got_q.size() < exp_q.size() - 1; i++) clk_step();
    commandType = DSR; param = 16'd5; commandReady = 1'b1;
    clk_step();
    commandReady = 1'b0;
    check("drop_last", 32'(dropped), 32'd1);
    check("drop_last_valid", 32'(tx_valid), 32'd0);
    check("drop_last_busy", 32'(busy), 32'd0);
    compare_got("drop_intact");
    start_req(DSR, 16'd5, 0, 0, 0, 0, ok);
    check("after_drop_dropped", 32'(dropped), 32'd0);
    drain(1'b0, "after_drop");

    // reset aborts an in-flight CPR
    start_req(DSR, 16'd6, 20, 30, 0, 0, ok);
    clk_step();
    clk_step();
    #2;
    rst = 1'b1;
    #1;
    stall_prev = 1'b0;
    check("abort_valid", 32'(tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data", 32'(tx_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) clk_step();
    check("abort_bytes", 32'(got_q.size()), 32'd2);
    check("abort_idle_valid", 32'(tx_valid), 32'd0);

    start_req(DSR, 16'd7, 5, 5, 0, 0, ok);     quiet(4, "dsr7");
    start_req(DECSTBM, 16'd0, 5, 5, 0, 0, ok); quiet(4, "decstbm");
    start_req(DA, 16'd1, 5, 5, 0, 0, ok);      quiet(4, "da1");

    start_req(DA, 16'd0, 0, 0, 0, 0, ok);      drain(1'b0, "post_reset_da");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
